// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by a word-addressed SRAM array.
// Independent read/write FSMs, byte strobes, OKAY/SLVERR/DECERR.
module axi_sram_slave #(
  parameter int MEM_AW = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [3:0]  awcache,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic        bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic        arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [3:0]  arcache,
  input  logic        arvalid,
  output logic        arready,
  output logic        rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int AW = MEM_AW + 2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_e;
  typedef enum logic {R_IDLE, R_DATA} rst_e;

  function automatic logic [AW-1:0] step(input logic [2:0] s);
    return AW'(1) << s;
  endfunction

  logic [31:0] mem [2**MEM_AW];

  logic unused_cache;
  assign unused_cache = ^{awcache, arcache};

  // write channel state
  wst_e          w_state_q, w_state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wlen_q, wlen_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic [2:0]    wsize_q, wsize_d;
  logic          wincr_q, wincr_d;
  logic          wdec_q, wdec_d;
  logic          wslv_q, wslv_d;
  logic          wlerr_q, wlerr_d;
  logic          bid_q, bid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          awready_q, wready_q, bvalid_q;
  logic          mem_we;
  logic          w_last;

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    wsize_d   = wsize_q;
    wincr_d   = wincr_q;
    wdec_d    = wdec_q;
    wslv_d    = wslv_q;
    wlerr_d   = wlerr_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    w_last    = (wcnt_q == wlen_q);
    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          waddr_d   = awaddr[AW-1:0];
          wlen_d    = awlen;
          wcnt_d    = 8'd0;
          wsize_d   = awsize;
          wincr_d   = (awburst == 2'b01);
          wdec_d    = |awaddr[31:AW];
          wslv_d    = (awsize > 3'd2) || awburst[1];
          wlerr_d   = 1'b0;
          bid_d     = awid;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          mem_we = !(wdec_q || wslv_q);
          if (wlast != w_last) wlerr_d = 1'b1;
          if (wincr_q) waddr_d = waddr_q + step(wsize_q);
          if (w_last) begin
            w_state_d = W_RESP;
            bresp_d   = wdec_q ? 2'b11 :
                        (wslv_q || wlerr_d) ? 2'b10 : 2'b00;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wsize_q   <= '0;
      wincr_q   <= 1'b0;
      wdec_q    <= 1'b0;
      wslv_q    <= 1'b0;
      wlerr_q   <= 1'b0;
      bid_q     <= 1'b0;
      bresp_q   <= 2'b00;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wsize_q   <= wsize_d;
      wincr_q   <= wincr_d;
      wdec_q    <= wdec_d;
      wslv_q    <= wslv_d;
      wlerr_q   <= wlerr_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      awready_q <= (w_state_d == W_IDLE);
      wready_q  <= (w_state_d == W_DATA);
      bvalid_q  <= (w_state_d == W_RESP);
    end
  end

  // contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr_q[AW-1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // read channel state
  rst_e          r_state_q, r_state_d;
  logic [AW-1:0] raddr_q, raddr_d, raddr_nx;
  logic [7:0]    rlen_q, rlen_d;
  logic [7:0]    rcnt_q, rcnt_d;
  logic [2:0]    rsize_q, rsize_d;
  logic          rincr_q, rincr_d;
  logic          rerr_q, rerr_d;
  logic          rid_q, rid_d;
  logic [1:0]    rresp_q, rresp_d;
  logic          rlast_q, rlast_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          arready_q, rvalid_q;
  logic          ar_dec, ar_slv;

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rsize_d   = rsize_q;
    rincr_d   = rincr_q;
    rerr_d    = rerr_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    ar_dec    = |araddr[31:AW];
    ar_slv    = (arsize > 3'd2) || arburst[1];
    raddr_nx  = rincr_q ? raddr_q + step(rsize_q) : raddr_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          raddr_d   = araddr[AW-1:0];
          rlen_d    = arlen;
          rcnt_d    = 8'd0;
          rsize_d   = arsize;
          rincr_d   = (arburst == 2'b01);
          rerr_d    = ar_dec || ar_slv;
          rid_d     = arid;
          rresp_d   = ar_dec ? 2'b11 : ar_slv ? 2'b10 : 2'b00;
          rlast_d   = (arlen == 8'd0);
          rdata_d   = (ar_dec || ar_slv) ? 32'd0 : mem[araddr[AW-1:2]];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && rready) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            raddr_d = raddr_nx;
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = (rcnt_d == rlen_q);
            rdata_d = rerr_q ? 32'd0 : mem[raddr_nx[AW-1:2]];
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rincr_q   <= 1'b0;
      rerr_q    <= 1'b0;
      rid_q     <= 1'b0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rsize_q   <= rsize_d;
      rincr_q   <= rincr_d;
      rerr_q    <= rerr_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      arready_q <= (r_state_d == R_IDLE);
      rvalid_q  <= (r_state_d == R_DATA);
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_axi_sram_slave;

  logic        clk, reset;
  logic        awid, awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bid, bvalid, bready;
  logic [1:0]  bresp;
  logic        arid, arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        rid, rlast, rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int checks = 0;
  int errors = 0;

  axi_sram_slave #(.MEM_AW(12)) dut (
    .clk(clk), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awcache(awcache),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arcache(arcache),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_aw(input logic id, input logic [31:0] a,
                       input logic [7:0] len, input logic [2:0] sz,
                       input logic [1:0] bu);
    int n;
    logic hs;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu;
    awvalid = 1'b1;
    n = 0;
    do begin
      hs = awready;
      tick();
      n++;
    end while (!hs && n < 50);
    awvalid = 1'b0;
    if (!hs) chk("aw_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s,
                      input logic l);
    int n;
    logic hs;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    n = 0;
    do begin
      hs = wready;
      tick();
      n++;
    end while (!hs && n < 50);
    wvalid = 1'b0;
    if (!hs) chk("w_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_b(input logic [1:0] er, input logic eid,
                      input string tag);
    int n;
    n = 0;
    while (!bvalid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    chk({tag, "_bresp"}, 32'(bresp), 32'(er));
    chk({tag, "_bid"}, 32'(bid), 32'(eid));
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_ar(input logic id, input logic [31:0] a,
                       input logic [7:0] len, input logic [2:0] sz,
                       input logic [1:0] bu);
    int n;
    logic hs;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu;
    arvalid = 1'b1;
    n = 0;
    do begin
      hs = arready;
      tick();
      n++;
    end while (!hs && n < 50);
    arvalid = 1'b0;
    if (!hs) chk("ar_timeout", 32'd0, 32'd1);
  endtask

  task automatic rbeat(input logic [31:0] ed, input logic el,
                       input logic [1:0] er, input string tag);
    int n;
    n = 0;
    while (!rvalid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, "_rdata"}, rdata, ed);
    chk({tag, "_rlast"}, 32'(rlast), 32'(el));
    chk({tag, "_rresp"}, 32'(rresp), 32'(er));
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    awcache = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    arcache = 0; arvalid = 0; rready = 0;

    // reset values
    tick();
    tick();
    chk("rst_ctl", {27'd0, awready, wready, bvalid, arready, rvalid},
        32'd0);
    chk("rst_ids", {26'd0, bid, bresp, rid, rresp, rlast}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_awready_pre", 32'(awready), 32'd0);
    tick();
    chk("rel_awready", 32'(awready), 32'd1);
    chk("rel_arready", 32'(arready), 32'd1);

    // single write then read, latency checks
    do_aw(1'b1, 32'h10, 8'd0, 3'd2, 2'b01);
    chk("t1_wready", 32'(wready), 32'd1);
    chk("t1_awready_lo", 32'(awready), 32'd0);
    do_w(32'hDEADBEEF, 4'hF, 1'b1);
    chk("t1_bvalid_lat", 32'(bvalid), 32'd1);
    do_b(2'b00, 1'b1, "t1");
    chk("t1_awready_back", 32'(awready), 32'd1);
    do_ar(1'b0, 32'h10, 8'd0, 3'd2, 2'b01);
    chk("t1_rvalid_lat", 32'(rvalid), 32'd1);
    chk("t1_rid", 32'(rid), 32'd0);
    rbeat(32'hDEADBEEF, 1'b1, 2'b00, "t1");
    chk("t1_rvalid_done", 32'(rvalid), 32'd0);
    chk("t1_arready_back", 32'(arready), 32'd1);

    // strobe merge
    do_aw(1'b0, 32'h20, 8'd0, 3'd2, 2'b01);
    do_w(32'hAAAAAAAA, 4'hF, 1'b1);
    do_b(2'b00, 1'b0, "sm0");
    do_aw(1'b0, 32'h20, 8'd0, 3'd2, 2'b01);
    do_w(32'h11223344, 4'b0101, 1'b1);
    do_b(2'b00, 1'b0, "sm1");
    do_ar(1'b1, 32'h20, 8'd0, 3'd2, 2'b01);
    chk("sm_rid", 32'(rid), 32'd1);
    rbeat(32'hAA22AA44, 1'b1, 2'b00, "sm");

    // INCR burst, read back with rready 1,0,1,0
    do_aw(1'b0, 32'h100, 8'd3, 3'd2, 2'b01);
    do_w(32'd1, 4'hF, 1'b0);
    do_w(32'd2, 4'hF, 1'b0);
    do_w(32'd3, 4'hF, 1'b0);
    do_w(32'd4, 4'hF, 1'b1);
    do_b(2'b00, 1'b0, "bw");
    do_ar(1'b0, 32'h100, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("br%0d_data", i), rdata, 32'(i + 1));
      chk($sformatf("br%0d_last", i), 32'(rlast), 32'(i == 3));
      rready = 1'b1;
      tick();
      rready = 1'b0;
      if (i < 3) begin
        tick();
        chk($sformatf("br%0d_stall_v", i), 32'(rvalid), 32'd1);
        chk($sformatf("br%0d_stall_d", i), rdata, 32'(i + 2));
      end
    end
    chk("br_end", 32'(rvalid), 32'd0);

    // DECERR write leaves memory alone
    do_aw(1'b0, 32'h0, 8'd0, 3'd2, 2'b01);
    do_w(32'h55, 4'hF, 1'b1);
    do_b(2'b00, 1'b0, "de0");
    do_aw(1'b1, 32'h0001_0000, 8'd0, 3'd2, 2'b01);
    do_w(32'hFFFFFFFF, 4'hF, 1'b1);
    do_b(2'b11, 1'b1, "de");
    do_ar(1'b0, 32'h0, 8'd0, 3'd2, 2'b01);
    rbeat(32'h55, 1'b1, 2'b00, "de_rd");
    do_ar(1'b0, 32'h0002_0000, 8'd0, 3'd2, 2'b01);
    rbeat(32'h0, 1'b1, 2'b11, "de_ar");

    // SLVERR read: size 3, two beats of zeros
    do_ar(1'b0, 32'h100, 8'd1, 3'd3, 2'b01);
    rbeat(32'h0, 1'b0, 2'b10, "sl0");
    rbeat(32'h0, 1'b1, 2'b10, "sl1");

    // early wlast: SLVERR but data still written
    do_aw(1'b1, 32'h30, 8'd1, 3'd2, 2'b01);
    do_w(32'h11, 4'hF, 1'b1);
    do_w(32'h22, 4'hF, 1'b0);
    do_b(2'b10, 1'b1, "wl");
    do_ar(1'b0, 32'h34, 8'd0, 3'd2, 2'b01);
    rbeat(32'h22, 1'b1, 2'b00, "wl_rd");

    // wrap across the top of the array
    do_aw(1'b0, 32'h3FFC, 8'd1, 3'd2, 2'b01);
    do_w(32'hA1, 4'hF, 1'b0);
    do_w(32'hB2, 4'hF, 1'b1);
    do_b(2'b00, 1'b0, "wr");
    do_ar(1'b0, 32'h3FFC, 8'd1, 3'd2, 2'b01);
    rbeat(32'hA1, 1'b0, 2'b00, "wr0");
    rbeat(32'hB2, 1'b1, 2'b00, "wr1");

    // read and write commit to the same word on the same edge
    do_aw(1'b0, 32'h40, 8'd0, 3'd2, 2'b01);
    do_w(32'd5, 4'hF, 1'b1);
    do_b(2'b00, 1'b0, "co0");
    do_aw(1'b0, 32'h40, 8'd0, 3'd2, 2'b01);
    wdata = 32'd9; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 1'b0; araddr = 32'h40; arlen = 8'd0; arsize = 3'd2;
    arburst = 2'b01; arvalid = 1'b1;
    chk("co_ready", 32'({wready, arready}), 32'd3);
    tick();
    wvalid = 1'b0;
    arvalid = 1'b0;
    rbeat(32'd5, 1'b1, 2'b00, "co_old");
    do_b(2'b00, 1'b0, "co1");
    do_ar(1'b0, 32'h40, 8'd0, 3'd2, 2'b01);
    rbeat(32'd9, 1'b1, 2'b00, "co_new");

    // reset in the middle of a read burst
    do_ar(1'b0, 32'h100, 8'd3, 3'd2, 2'b01);
    rbeat(32'd1, 1'b0, 2'b00, "mr0");
    rbeat(32'd2, 1'b0, 2'b00, "mr1");
    chk("mr2_data", rdata, 32'd3);
    reset = 1'b0;
    #1;
    chk("mr_rvalid", 32'(rvalid), 32'd0);
    chk("mr_arready", 32'(arready), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("mr_arready_back", 32'(arready), 32'd1);
    do_ar(1'b1, 32'h104, 8'd0, 3'd2, 2'b01);
    chk("mr_rid", 32'(rid), 32'd1);
    rbeat(32'd2, 1'b1, 2'b00, "mr_new");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 slave (responder) backed by an on-chip word-addressed SRAM array. It is the far end of the data and instruction AXI master ports that the PE's MMU drives. It accepts single-beat and INCR/FIXED bursts on independent read and write channels, performs byte-strobed writes, and returns OKAY, SLVERR or DECERR responses. It serves as the local memory model in PE-level simulation and as BRAM-backed memory in FPGA bring-up.

## Interface
- MEM_AW, 12, word-address width; the array holds 2^MEM_AW 32-bit words.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- awid  in  1  write ID, latched on AW handshake.
- awaddr  in  32  write start byte address.
- awlen  in  8  beats minus one.
- awsize  in  3  bytes per beat, log2.
- awburst  in  2  00 FIXED, 01 INCR; other values are errors.
- awcache  in  4  ignored.
- awvalid / awready  in / out  1  AW handshake.
- wdata  in  32  write data.
- wstrb  in  4  byte enables.
- wlast  in  1  last write beat.
- wvalid / wready  in / out  1  W handshake.
- bid  out  1  equals the latched awid.
- bresp  out  2  write response.
- bvalid / bready  out / in  1  B handshake.
- arid, araddr, arlen, arsize, arburst, arcache  in  1/32/8/3/2/4  read address fields; same meaning as the AW fields.
- arvalid / arready  in / out  1  AR handshake.
- rid  out  1  equals the latched arid.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rlast  out  1  last read beat.
- rvalid / rready  out / in  1  R handshake.

## Operation
- The write FSM and the read FSM are independent. Both may be active at the same time.
- **Write FSM, W_IDLE:** awready=1. On awvalid, latch id, addr, len, size, burst; set beat counter to 0; clear the error flags; go to W_DATA.
- **Write FSM, W_DATA:** wready=1. Each wvalid beat writes the bytes enabled by wstrb into mem[addr[MEM_AW+1:2]], unless an error is flagged.
  - After each beat, INCR adds (1<<size) to addr. FIXED holds addr.
  - When the counter equals len on a beat, go to W_RESP; otherwise increment the counter.
- **Write FSM, W_RESP:** bvalid=1. Hold bid and bresp until bready, then go to W_IDLE.
- **Read FSM, R_IDLE:** arready=1. On arvalid, latch the fields, load rdata from mem at araddr, go to R_DATA.
- **Read FSM, R_DATA:** rvalid=1, and rlast=1 when the counter equals len.
  - On rready with a non-last beat: advance addr and load the next word into rdata, so rvalid stays high (back-to-back beats).
  - On rready with the last beat: go to R_IDLE.
- **Response codes:** OKAY=00, SLVERR=10, DECERR=11.
  - **DECERR:** addr[31:MEM_AW+2] is nonzero at burst start. Writes are suppressed; rdata=0.
  - **SLVERR:** size>2, or burst is 10/11. Data is still consumed or produced for len+1 beats; writes are suppressed; rdata=0.
  - **Write SLVERR (wlast mismatch):** wlast disagrees with (counter==len) on any beat. The burst still ends on beat len; writes are performed. DECERR takes priority over SLVERR.
- **Response per beat:** the read response code is decided at AR handshake and is the same on every beat.
- **Narrow transfers:** a read returns the full aligned word. Lane selection is by the master's wstrb.
- **Address wrap:** the internal address wraps modulo 2^(MEM_AW+2). A burst crossing the top of the array continues at word 0, with no error.
- **Memory contents:** not reset.

## Timing
- **Reset values:** awready=0, wready=0, bvalid=0, bresp=00, bid=0, arready=0, rvalid=0, rlast=0, rresp=00, rid=0, rdata=0. Both FSMs are in IDLE.
- All handshake outputs are registered. awready and arready rise on the first clk edge after reset deasserts.
- **Write latency:** the AW handshake is at edge N, so wready=1 from N+1. The last W beat is at edge M, so bvalid=1 from M+1. awready returns the cycle after the B handshake.
- **Read latency:** the AR handshake is at edge N, so rvalid=1 and the first data appear from N+1.
  - One beat per cycle while rready=1.
  - arready returns the cycle after the last R handshake.
- **R stall:** rdata, rresp, rlast and rid are stable while rvalid=1 and rready=0.
- **Read/write collision:** if the read loads a word in the same cycle a write commits to that word, the read returns the old contents.
- **Reset mid-burst:** the transaction is abandoned; no B or R response is issued. Words already written are retained.

## Test plan
- **Single write then read:** AW addr 0x10 len 0 size 2 INCR, W 0xDEADBEEF wstrb F -> B OKAY one cycle after W. AR 0x10 -> rdata 0xDEADBEEF, rlast=1, rresp 00.
- **Strobe merge:** write 0x11223344 wstrb 0101 over 0xAAAAAAAA at 0x20 -> read returns 0xAA22AA44.
- **Burst with stalls:** INCR len 3 writes 1,2,3,4 to 0x100. Read back with rready toggling 1,0,1,0 -> beats 1,2,3,4; rdata held during stalls; rlast only on beat 4.
- **Errors:**
  - awaddr 0x0001_0000 (MEM_AW=12) -> bresp 11; memory unchanged.
  - arsize 3 len 1 -> two beats, rdata 0, rresp 10.
  - Early wlast on beat 0 of len 1 -> bresp 10.
- **Concurrency:** simultaneous AW and AR to the same word 0x40 (old 5, new 9) -> read returns 5; a later read returns 9.
- **Reset mid-burst:** assert reset during beat 2 of a len-3 read -> rvalid=0 immediately. arready=1 one edge after release; a new AR completes normally.
